// File: rtl/srio_target_manage.sv
// SRIO target-side receive manager: address-window checking, packet/byte counters, doorbell capture.
// Define SRIO_TGT_TIMEOUT_EN to build the receive watchdog (idle counter and timeout_limit at 0x24).
module srio_target_manage (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        srio_single_rdn,
  input  logic        srio_single_wrn,
  input  logic        srio_single_csn,
  input  logic [7:0]  srio_single_addr,
  input  logic [31:0] srio_single_dout,
  output logic [31:0] srio_single_din,
  input  logic        tgt_wr_valid,
  input  logic [33:0] tgt_wr_addr,
  input  logic [8:0]  tgt_wr_len,
  input  logic        tgt_db_valid,
  input  logic [15:0] tgt_db_info,
  input  logic [7:0]  tgt_db_src_id,
  output logic        rx_done_irq,
  output logic        rx_busy,
  output logic        rx_err
);
  typedef enum logic [1:0] {StIdle, StRecv, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] win_base_q, win_base_d, win_end_q, win_end_d, exp_pkts_q, exp_pkts_d;
  logic [31:0] rx_pkts_q, rx_pkts_d, rx_bytes_q, rx_bytes_d, addr_err_q, addr_err_d;
  logic [23:0] last_db_q, last_db_d;
  logic [31:0] din_q, din_d, rd_data;
  logic        err_q, err_d, irq_q, irq_d;
  logic        wr_en, rd_en, arm, clr, in_win, timeout_bit;
  logic [32:0] pkt_last;

`ifdef SRIO_TGT_TIMEOUT_EN
  logic [31:0] timeout_limit_q, timeout_limit_d, idle_cnt_q, idle_cnt_d;
  logic        timeout_q, timeout_d;
  assign timeout_bit = timeout_q;
`else
  assign timeout_bit = 1'b0;
`endif

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  assign wr_en = ~srio_single_wrn & ~srio_single_csn;
  assign rd_en = ~srio_single_rdn & ~srio_single_csn;
  assign arm   = wr_en && (srio_single_addr == 8'h0C) && srio_single_dout[0];
  assign clr   = wr_en && (srio_single_addr == 8'h0C) && srio_single_dout[1];

  // 33-bit end address so a wrap past 2^32 lands above any 32-bit win_end.
  assign pkt_last = {1'b0, tgt_wr_addr[31:0]} + {24'd0, tgt_wr_len} - 33'd1;
  assign in_win   = (tgt_wr_addr[33:32] == 2'b00) && (tgt_wr_addr[31:0] >= win_base_q) &&
                    (pkt_last <= {1'b0, win_end_q});

  always_comb begin
    state_d    = state_q;
    win_base_d = win_base_q;
    win_end_d  = win_end_q;
    exp_pkts_d = exp_pkts_q;
    rx_pkts_d  = rx_pkts_q;
    rx_bytes_d = rx_bytes_q;
    addr_err_d = addr_err_q;
    last_db_d  = last_db_q;
    err_d      = err_q;
`ifdef SRIO_TGT_TIMEOUT_EN
    timeout_limit_d = timeout_limit_q;
    idle_cnt_d      = idle_cnt_q;
    timeout_d       = timeout_q;
`endif
    if (wr_en) begin
      case (srio_single_addr)
        8'h00:   win_base_d = srio_single_dout;
        8'h04:   win_end_d  = srio_single_dout;
        8'h08:   exp_pkts_d = srio_single_dout;
`ifdef SRIO_TGT_TIMEOUT_EN
        8'h24:   timeout_limit_d = srio_single_dout;
`endif
        default: ;
      endcase
    end
    if (tgt_db_valid) last_db_d = {tgt_db_src_id, tgt_db_info};

    unique case (state_q)
      StIdle, StDone: begin
        if (arm) begin
          state_d    = StRecv;
          rx_pkts_d  = '0;
          rx_bytes_d = '0;
          addr_err_d = '0;
          err_d      = 1'b0;
`ifdef SRIO_TGT_TIMEOUT_EN
          idle_cnt_d = '0;
          timeout_d  = 1'b0;
`endif
        end
      end
      StRecv: begin
        if (tgt_wr_valid) begin
          if (in_win) begin
            rx_pkts_d  = sat_add(rx_pkts_q, 32'd1);
            rx_bytes_d = sat_add(rx_bytes_q, {23'd0, tgt_wr_len});
          end else begin
            addr_err_d = sat_add(addr_err_q, 32'd1);
            err_d      = 1'b1;
          end
        end
`ifdef SRIO_TGT_TIMEOUT_EN
        idle_cnt_d = tgt_wr_valid ? '0 : sat_add(idle_cnt_q, 32'd1);
`endif
        // Compare against the count including any packet landing this same cycle.
        if (tgt_db_valid && (tgt_db_info == 16'd1)) begin
          state_d = StDone;
          if (rx_pkts_d != exp_pkts_q) err_d = 1'b1;
        end
`ifdef SRIO_TGT_TIMEOUT_EN
        else if ((timeout_limit_q != '0) && (idle_cnt_d == timeout_limit_q)) begin
          state_d   = StDone;
          timeout_d = 1'b1;
          err_d     = 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    if (clr) begin
      state_d    = StIdle;
      rx_pkts_d  = '0;
      rx_bytes_d = '0;
      addr_err_d = '0;
      last_db_d  = '0;
      err_d      = 1'b0;
`ifdef SRIO_TGT_TIMEOUT_EN
      idle_cnt_d = '0;
      timeout_d  = 1'b0;
`endif
    end
    irq_d = (state_d == StDone) && (state_q != StDone);
  end

  always_comb begin
    rd_data = '0;
    case (srio_single_addr)
      8'h00:   rd_data = win_base_q;
      8'h04:   rd_data = win_end_q;
      8'h08:   rd_data = exp_pkts_q;
      8'h10:   rd_data = {28'd0, timeout_bit, err_q, state_q == StDone, state_q == StRecv};
      8'h14:   rd_data = rx_pkts_q;
      8'h18:   rd_data = rx_bytes_q;
      8'h1C:   rd_data = addr_err_q;
      8'h20:   rd_data = {8'd0, last_db_q};
`ifdef SRIO_TGT_TIMEOUT_EN
      8'h24:   rd_data = timeout_limit_q;
`endif
      default: rd_data = '0;
    endcase
    din_d = rd_en ? rd_data : din_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      win_base_q <= '0;
      win_end_q  <= '0;
      exp_pkts_q <= '0;
      rx_pkts_q  <= '0;
      rx_bytes_q <= '0;
      addr_err_q <= '0;
      last_db_q  <= '0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
      din_q      <= '0;
`ifdef SRIO_TGT_TIMEOUT_EN
      timeout_limit_q <= '0;
      idle_cnt_q      <= '0;
      timeout_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      win_base_q <= win_base_d;
      win_end_q  <= win_end_d;
      exp_pkts_q <= exp_pkts_d;
      rx_pkts_q  <= rx_pkts_d;
      rx_bytes_q <= rx_bytes_d;
      addr_err_q <= addr_err_d;
      last_db_q  <= last_db_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
      din_q      <= din_d;
`ifdef SRIO_TGT_TIMEOUT_EN
      timeout_limit_q <= timeout_limit_d;
      idle_cnt_q      <= idle_cnt_d;
      timeout_q       <= timeout_d;
`endif
    end
  end

  assign srio_single_din = din_q;
  assign rx_done_irq     = irq_q;
  assign rx_busy         = (state_q == StRecv);
  assign rx_err          = err_q;
endmodule

// File: tb/tb_srio_target_manage.sv
// Bench for srio_target_manage: constant vector table, directed sequences and random traffic
// checked against a transaction-level model of the receive manager.
module tb_srio_target_manage;
  logic        sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic        srio_single_rdn = 1'b1, srio_single_wrn = 1'b1, srio_single_csn = 1'b1;
  logic [7:0]  srio_single_addr = '0;
  logic [31:0] srio_single_dout = '0, srio_single_din;
  logic        tgt_wr_valid = 1'b0, tgt_db_valid = 1'b0;
  logic [33:0] tgt_wr_addr = '0;
  logic [8:0]  tgt_wr_len = '0;
  logic [15:0] tgt_db_info = '0;
  logic [7:0]  tgt_db_src_id = '0;
  logic        rx_done_irq, rx_busy, rx_err;

  srio_target_manage dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .srio_single_rdn(srio_single_rdn), .srio_single_wrn(srio_single_wrn),
    .srio_single_csn(srio_single_csn), .srio_single_addr(srio_single_addr),
    .srio_single_dout(srio_single_dout), .srio_single_din(srio_single_din),
    .tgt_wr_valid(tgt_wr_valid), .tgt_wr_addr(tgt_wr_addr), .tgt_wr_len(tgt_wr_len),
    .tgt_db_valid(tgt_db_valid), .tgt_db_info(tgt_db_info), .tgt_db_src_id(tgt_db_src_id),
    .rx_done_irq(rx_done_irq), .rx_busy(rx_busy), .rx_err(rx_err)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0, errors = 0, irq_seen = 0;
  always @(posedge sys_clk) if (rx_done_irq) irq_seen++;

  // Reference model: 0 = idle, 1 = receiving, 2 = done.
  localparam longint Max32 = 64'h0000_0000_FFFF_FFFF;
  longint m_base, m_end, m_exp, m_limit, m_pkts, m_bytes, m_aerr;
  bit m_err, m_to;
  int m_state, m_irq;
  logic [23:0] m_db;

  function automatic longint sat(input longint v);
    return (v > Max32) ? Max32 : v;
  endfunction

  task automatic m_reset();
    m_base = 0; m_end = 0; m_exp = 0; m_limit = 0; m_pkts = 0; m_bytes = 0; m_aerr = 0;
    m_err = 0; m_to = 0; m_state = 0; m_db = '0;
  endtask

  task automatic m_cycle(input bit pkt, input logic [33:0] a, input int len, input bit db,
                         input logic [15:0] info, input logic [7:0] src, input bit arm,
                         input bit clr);
    longint la;
    if (clr) begin
      m_pkts = 0; m_bytes = 0; m_aerr = 0; m_err = 0; m_to = 0; m_db = '0; m_state = 0;
      return;
    end
    if (db) m_db = {src, info};
    if (arm && m_state != 1) begin
      m_state = 1; m_pkts = 0; m_bytes = 0; m_aerr = 0; m_err = 0; m_to = 0;
      return;
    end
    if (m_state != 1) return;
    if (pkt) begin
      la = longint'(a);
      if (la <= Max32 && la >= m_base && la + len - 1 <= m_end) begin
        m_pkts = sat(m_pkts + 1); m_bytes = sat(m_bytes + len);
      end else begin
        m_aerr = sat(m_aerr + 1); m_err = 1;
      end
    end
    if (db && info == 16'd1) begin
      m_state = 2; m_irq++;
      if (m_pkts != m_exp) m_err = 1;
    end
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h00: return 32'(m_base);
      8'h04: return 32'(m_end);
      8'h08: return 32'(m_exp);
      8'h10: return {28'd0, m_to, m_err, m_state == 2, m_state == 1};
      8'h14: return 32'(m_pkts);
      8'h18: return 32'(m_bytes);
      8'h1C: return 32'(m_aerr);
      8'h20: return {8'd0, m_db};
`ifdef SRIO_TGT_TIMEOUT_EN
      8'h24: return 32'(m_limit);
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge sys_clk);
    srio_single_csn = 0; srio_single_wrn = 0; srio_single_addr = a; srio_single_dout = d;
    @(negedge sys_clk);
    srio_single_csn = 1; srio_single_wrn = 1;
    if (a == 8'h0C) m_cycle(0, '0, 1, 0, '0, '0, d[0], d[1]);
    else case (a)
      8'h00: m_base = longint'(d);
      8'h04: m_end = longint'(d);
      8'h08: m_exp = longint'(d);
`ifdef SRIO_TGT_TIMEOUT_EN
      8'h24: m_limit = longint'(d);
`endif
      default: ;
    endcase
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge sys_clk);
    srio_single_csn = 0; srio_single_rdn = 0; srio_single_addr = a;
    @(negedge sys_clk);
    srio_single_csn = 1; srio_single_rdn = 1;
    d = srio_single_din;
  endtask

  task automatic chk_reg(input string name, input logic [7:0] a);
    logic [31:0] d;
    bus_rd(a, d);
    chk(name, d, m_read(a));
  endtask

  task automatic chk_const(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    chk(name, d, exp);
  endtask

  task automatic ev(input bit pkt, input logic [33:0] a, input int len, input bit db,
                    input logic [15:0] info, input logic [7:0] src);
    @(negedge sys_clk);
    tgt_wr_valid = pkt; tgt_wr_addr = a; tgt_wr_len = 9'(len);
    tgt_db_valid = db; tgt_db_info = info; tgt_db_src_id = src;
    @(negedge sys_clk);
    tgt_wr_valid = 0; tgt_db_valid = 0;
    m_cycle(pkt, a, len, db, info, src, 0, 0);
  endtask

  task automatic chk_all();
    chk_reg("status", 8'h10);
    chk_reg("rx_pkts", 8'h14);
    chk_reg("rx_bytes", 8'h18);
    chk_reg("addr_err_cnt", 8'h1C);
    chk_reg("last_db", 8'h20);
    chk("rx_busy", {31'd0, rx_busy}, {31'd0, m_state == 1});
    chk("rx_err", {31'd0, rx_err}, {31'd0, m_err});
    chk("irq_count", 32'(irq_seen), 32'(m_irq));
  endtask

  typedef struct {
    logic [33:0] addr;
    int          len;
    logic [31:0] pkts;
    logic [31:0] bytes;
    logic [31:0] aerr;
  } vec_t;
  vec_t vecs[7];

  initial begin
    logic [31:0] d;
    int irq0, n, r;
    logic [33:0] a;
    m_reset(); m_irq = 0;
    // Window 0x100..0x10FF
    vecs[0] = '{34'h0_0000_0100, 256, 32'd1, 32'd256, 32'd0};
    vecs[1] = '{34'h0_0000_1000, 256, 32'd1, 32'd256, 32'd0};
    vecs[2] = '{34'h0_0000_1080, 256, 32'd0, 32'd0,   32'd1};
    vecs[3] = '{34'h0_0000_00FF, 1,   32'd0, 32'd0,   32'd1};
    vecs[4] = '{34'h0_0000_10FF, 1,   32'd1, 32'd1,   32'd0};
    vecs[5] = '{34'h1_0000_0100, 4,   32'd0, 32'd0,   32'd1};
    vecs[6] = '{34'h0_0000_10FF, 2,   32'd0, 32'd0,   32'd1};

    #1;
    chk("rst_din", srio_single_din, 32'd0);
    chk("rst_outs", {29'd0, rx_done_irq, rx_busy, rx_err}, 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1;
    chk_reg("rst_win_base", 8'h00);
    chk_reg("rst_status", 8'h10);

    bus_wr(8'h00, 32'h100); bus_wr(8'h04, 32'h10FF);
    foreach (vecs[i]) begin
      bus_wr(8'h0C, 32'd2); bus_wr(8'h0C, 32'd1);
      ev(1, vecs[i].addr, vecs[i].len, 0, '0, '0);
      bus_rd(8'h14, d); chk($sformatf("vec%0d_pkts", i), d, vecs[i].pkts);
      bus_rd(8'h18, d); chk($sformatf("vec%0d_bytes", i), d, vecs[i].bytes);
      bus_rd(8'h1C, d); chk($sformatf("vec%0d_aerr", i), d, vecs[i].aerr);
      chk($sformatf("vec%0d_rx_err", i), {31'd0, rx_err}, vecs[i].aerr);
    end

    // Basic receive of four full packets then end-of-transfer doorbell.
    bus_wr(8'h0C, 32'd2); bus_wr(8'h08, 32'd4); bus_wr(8'h0C, 32'd1);
    irq0 = irq_seen;
    for (int i = 1; i <= 4; i++) ev(1, 34'(i * 256), 256, 0, '0, '0);
    ev(0, '0, 1, 1, 16'd1, 8'h5A);
    chk_const("basic_pkts", 8'h14, 32'd4);
    chk_const("basic_bytes", 8'h18, 32'd1024);
    chk_const("basic_status", 8'h10, 32'h2);
    chk_const("basic_last_db", 8'h20, 32'h005A_0001);
    chk("basic_irq", 32'(irq_seen - irq0), 32'd1);

    // Re-arm from done; packet crossing win_end.
    bus_wr(8'h0C, 32'd1);
    ev(1, 34'h1080, 256, 0, '0, '0);
    chk_const("oow_aerr", 8'h1C, 32'd1);
    chk_const("oow_pkts", 8'h14, 32'd0);
    chk("oow_rx_err", {31'd0, rx_err}, 32'd1);

    // Early doorbell after two packets.
    bus_wr(8'h0C, 32'd2); bus_wr(8'h0C, 32'd1);
    ev(1, 34'h100, 256, 0, '0, '0); ev(1, 34'h200, 256, 0, '0, '0);
    ev(0, '0, 1, 1, 16'd1, 8'h01);
    chk_const("early_status", 8'h10, 32'h6);

    // Other doorbell info is recorded only; last packet and doorbell in the same cycle.
    bus_wr(8'h0C, 32'd2); bus_wr(8'h0C, 32'd1);
    for (int i = 1; i <= 3; i++) ev(1, 34'(i * 256), 256, 0, '0, '0);
    ev(0, '0, 1, 1, 16'd5, 8'h33);
    chk_const("db_other_status", 8'h10, 32'h1);
    chk_const("db_other_last", 8'h20, 32'h0033_0005);
    ev(1, 34'h400, 256, 1, 16'd1, 8'h44);
    chk_const("simul_pkts", 8'h14, 32'd4);
    chk_const("simul_status", 8'h10, 32'h2);
    bus_wr(8'h0C, 32'd3);
    chk_const("clr_status", 8'h10, 32'h0);
    chk_const("clr_pkts", 8'h14, 32'd0);
    chk_const("clr_bytes", 8'h18, 32'd0);
    chk_const("clr_last_db", 8'h20, 32'd0);

    // Idle packets ignored; window write during RECV; 32-bit wrap.
    ev(1, 34'h100, 16, 0, '0, '0);
    chk_const("idle_pkts", 8'h14, 32'd0);
    bus_wr(8'h0C, 32'd1); bus_wr(8'h04, 32'h1FF);
    ev(1, 34'h100, 256, 0, '0, '0); ev(1, 34'h180, 256, 0, '0, '0);
    chk_const("live_end_pkts", 8'h14, 32'd1);
    chk_const("live_end_aerr", 8'h1C, 32'd1);
    bus_wr(8'h04, 32'hFFFF_FFFF);
    ev(1, 34'hFFFF_FF00, 256, 0, '0, '0); ev(1, 34'hFFFF_FFFF, 2, 0, '0, '0);
    chk_const("wrap_pkts", 8'h14, 32'd2);
    chk_const("wrap_aerr", 8'h1C, 32'd2);

    // Random traffic against the model.
    bus_wr(8'h0C, 32'd2);
    bus_wr(8'h00, 32'($urandom_range(0, 4096)));
    bus_wr(8'h04, 32'(m_base) + 32'($urandom_range(0, 8192)));
    bus_wr(8'h08, 32'($urandom_range(0, 5)));
    bus_wr(8'h0C, 32'd1);
    for (int it = 0; it < 400; it++) begin
      r = int'($urandom_range(0, 19));
      a = {($urandom_range(0, 15) == 0) ? 2'b01 : 2'b00, 32'($urandom_range(0, 16384))};
      n = int'($urandom_range(1, 256));
      if (r < 10) ev(1, a, n, 0, '0, '0);
      else if (r < 13) ev(1, a, n, 1, 16'($urandom_range(0, 2)), 8'($urandom));
      else if (r < 15) ev(0, '0, 1, 1, 16'($urandom_range(0, 2)), 8'($urandom));
      else if (r == 15) bus_wr(8'h0C, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(2, 3)) : 32'd1);
      else if (r == 16) bus_wr(8'($urandom_range(0, 2) * 4), 32'($urandom_range(0, 12000)));
      else chk_all();
      chk("rnd_busy", {31'd0, rx_busy}, {31'd0, m_state == 1});
      chk("rnd_err", {31'd0, rx_err}, {31'd0, m_err});
    end
    chk_all();

`ifdef SRIO_TGT_TIMEOUT_EN
    bus_wr(8'h0C, 32'd2); bus_wr(8'h24, 32'd100);
    chk_reg("limit_rd", 8'h24);
    irq0 = irq_seen;
    bus_wr(8'h0C, 32'd1);
    n = 0;
    while (rx_busy && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'd100);
    m_state = 2; m_to = 1; m_err = 1; m_irq++;
    chk_const("timeout_status", 8'h10, 32'hE);
    chk("timeout_irq", 32'(irq_seen - irq0), 32'd1);
`else
    bus_wr(8'h24, 32'd55);
    chk_const("no_wdog_0x24", 8'h24, 32'd0);
`endif

    // Reset in the middle of a receive.
    bus_wr(8'h0C, 32'd2); bus_wr(8'h00, 32'h100); bus_wr(8'h04, 32'h10FF);
    bus_wr(8'h08, 32'd4); bus_wr(8'h0C, 32'd1);
    ev(1, 34'h100, 256, 0, '0, '0);
    bus_rd(8'h00, d);
    chk("pre_rst_din", d, 32'h100);
    irq0 = irq_seen;
    @(negedge sys_clk);
    sys_rst_n = 0;
    #1;
    chk("mid_rst_din", srio_single_din, 32'd0);
    chk("mid_rst_outs", {29'd0, rx_done_irq, rx_busy, rx_err}, 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1;
    m_reset();
    chk_reg("post_rst_base", 8'h00);
    chk_reg("post_rst_pkts", 8'h14);
    chk_reg("post_rst_status", 8'h10);
    chk("post_rst_irq", 32'(irq_seen - irq0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
